// File: rtl/dcache_port_arb_pkg.sv
// Shared types for the data-cache port arbiter: FSM states, memory op encoding, request payload.
package dcache_port_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    MEM_OP_READ  = 1'b0,
    MEM_OP_WRITE = 1'b1
  } mem_op_e;

  typedef struct packed {
    mem_op_e             op;
    logic [ADDR_W-1:0]   addr;
    logic [BE_W-1:0]     wtype;
    logic [DATA_W-1:0]   wdata;
  } mem_req_t;

endpackage

// File: rtl/dcache_port_arb_starve_ctr.sv
// Counts consecutive arbitration losses of requester 1 and requests a forced grant once the limit is hit.
module arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic rq1_valid,
  input  logic grant0,
  input  logic grant1,
  output logic force_rq1_c
);

  logic [CNT_W-1:0] cnt;

  // Any cycle without a waiting rq1 clears the history; losses saturate.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!rq1_valid || grant1) begin
      cnt <= '0;
    end else if (grant0 && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign force_rq1_c = (cnt >= CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/dcache_port_arb.sv
// Two-requester arbiter for the single dcache request port: one outstanding access,
// response routed to the owner, responses of flushed exe requests suppressed.
module dcache_port_arb
  import dcache_port_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              rq0_valid,
  input  logic              rq0_op,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [BE_W-1:0]   rq0_wtype,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_ready,
  output logic              rq0_resp_valid,
  output logic [DATA_W-1:0] rq0_rdata,
  input  logic              rq1_valid,
  input  logic              rq1_op,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [BE_W-1:0]   rq1_wtype,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_ready,
  output logic              rq1_resp_valid,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              c_valid,
  output logic              c_op,
  output logic [ADDR_W-1:0] c_addr,
  output logic [BE_W-1:0]   c_write_type,
  output logic [DATA_W-1:0] c_wdata,
  input  logic              c_data_valid,
  input  logic [DATA_W-1:0] c_rdata,
  output logic              busy
);

  arb_state_e state;
  logic       owner;
  logic       drop;
  mem_req_t   creq;
  logic       c_valid_q;
  logic       busy_q;

  logic       accept_c;
  logic       elig0_c;
  logic       grant0_c;
  logic       grant1_c;
  logic       force_rq1_c;
  logic       resp_fire_c;
  mem_req_t   rq0_req_c;
  mem_req_t   rq1_req_c;

  assign rq0_req_c = '{op: mem_op_e'(rq0_op), addr: rq0_addr, wtype: rq0_wtype, wdata: rq0_wdata};
  assign rq1_req_c = '{op: mem_op_e'(rq1_op), addr: rq1_addr, wtype: rq1_wtype, wdata: rq1_wdata};

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clk         (clk),
    .rstn        (rstn),
    .rq1_valid   (rq1_valid),
    .grant0      (grant0_c),
    .grant1      (grant1_c),
    .force_rq1_c (force_rq1_c)
  );

  // Grant: rq0 first unless flushed or rq1 has starved long enough.
  always_comb begin
    accept_c    = (state == ARB_IDLE) || ((state == ARB_WAIT) && c_data_valid);
    elig0_c     = rq0_valid && !flush;
    grant1_c    = accept_c && rq1_valid && (force_rq1_c || !elig0_c);
    grant0_c    = accept_c && elig0_c && !grant1_c;
    resp_fire_c = (state == ARB_WAIT) && c_data_valid;
  end

  assign rq0_ready = grant0_c;
  assign rq1_ready = grant1_c;

  // A flush on the completion cycle kills the rq0 response immediately.
  assign rq0_resp_valid = resp_fire_c && !owner && !(drop || flush);
  assign rq1_resp_valid = resp_fire_c && owner;
  assign rq0_rdata      = (resp_fire_c && !owner) ? c_rdata : '0;
  assign rq1_rdata      = (resp_fire_c && owner)  ? c_rdata : '0;

  assign c_valid      = c_valid_q;
  assign c_op         = creq.op;
  assign c_addr       = creq.addr;
  assign c_write_type = creq.wtype;
  assign c_wdata      = creq.wdata;
  assign busy         = busy_q;

  // Sequencer: a grant always lands in ISSUE, so WAIT->ISSUE chains without a bubble.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ARB_IDLE;
      owner     <= 1'b0;
      drop      <= 1'b0;
      creq      <= '0;
      c_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      c_valid_q <= 1'b0;
      if (grant0_c || grant1_c) begin
        state     <= ARB_ISSUE;
        owner     <= grant1_c;
        drop      <= 1'b0;
        creq      <= grant1_c ? rq1_req_c : rq0_req_c;
        c_valid_q <= 1'b1;
        busy_q    <= 1'b1;
      end else begin
        if (flush && !owner && (state != ARB_IDLE)) begin
          drop <= 1'b1;
        end
        unique case (state)
          ARB_ISSUE: begin
            state  <= ARB_WAIT;
            busy_q <= 1'b1;
          end
          ARB_WAIT: begin
            if (c_data_valid) begin
              state  <= ARB_IDLE;
              busy_q <= 1'b0;
            end
          end
          default: begin
            state  <= ARB_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcache_port_arb.sv
// Bench for dcache_port_arb: directed vector table, corner-case sequences, random run against a transaction model.
module tb_dcache_port_arb;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        rq0_valid = 1'b0, rq0_op = 1'b0;
  logic [31:0] rq0_addr = '0, rq0_wdata = '0;
  logic [3:0]  rq0_wtype = '0;
  logic        rq0_ready, rq0_resp_valid;
  logic [31:0] rq0_rdata;
  logic        rq1_valid = 1'b0, rq1_op = 1'b0;
  logic [31:0] rq1_addr = '0, rq1_wdata = '0;
  logic [3:0]  rq1_wtype = '0;
  logic        rq1_ready, rq1_resp_valid;
  logic [31:0] rq1_rdata;
  logic        c_valid, c_op;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_write_type;
  logic        c_data_valid = 1'b0;
  logic [31:0] c_rdata = '0;
  logic        busy;

  always #5 clk = ~clk;

  dcache_port_arb #(.STARVE_LIMIT(STARVE), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .rq0_valid(rq0_valid), .rq0_op(rq0_op), .rq0_addr(rq0_addr), .rq0_wtype(rq0_wtype),
    .rq0_wdata(rq0_wdata), .rq0_ready(rq0_ready), .rq0_resp_valid(rq0_resp_valid), .rq0_rdata(rq0_rdata),
    .rq1_valid(rq1_valid), .rq1_op(rq1_op), .rq1_addr(rq1_addr), .rq1_wtype(rq1_wtype),
    .rq1_wdata(rq1_wdata), .rq1_ready(rq1_ready), .rq1_resp_valid(rq1_resp_valid), .rq1_rdata(rq1_rdata),
    .c_valid(c_valid), .c_op(c_op), .c_addr(c_addr), .c_write_type(c_write_type), .c_wdata(c_wdata),
    .c_data_valid(c_data_valid), .c_rdata(c_rdata), .busy(busy)
  );

  typedef struct {
    bit rstn, flush, v0, op0;
    bit [31:0] a0, wd0;
    bit [3:0] wt0;
    bit v1, op1;
    bit [31:0] a1, wd1;
    bit [3:0] wt1;
    bit cdv;
    bit [31:0] crd;
  } stim_t;

  typedef struct {
    bit rdy0, rdy1, rv0, rv1, cv, busy;
    bit [31:0] rd, caddr, cwd;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Transaction-level model: an access is either due to be issued or in flight.
  bit m_issue = 0, m_flight = 0, m_owner = 0, m_drop = 0;
  int m_losses = 0;
  bit m_op = 0;
  bit [31:0] m_addr = '0, m_wdata = '0;
  bit [3:0] m_wtype = '0;

  bit s_rdy0, s_rdy1, s_rv0, s_rv1, s_busy, s_cv;
  bit [31:0] s_rd1, s_caddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(bit r, bit fl, bit v0, bit op0, bit [31:0] a0, bit [31:0] wd0,
                               bit v1, bit [31:0] a1, bit cdv, bit [31:0] crd);
    stim_t s;
    s.rstn = r; s.flush = fl;
    s.v0 = v0; s.op0 = op0; s.a0 = a0; s.wd0 = wd0; s.wt0 = op0 ? 4'hF : 4'h0;
    s.v1 = v1; s.op1 = 1'b0; s.a1 = a1; s.wd1 = '0; s.wt1 = '0;
    s.cdv = cdv; s.crd = crd;
    return s;
  endfunction

  function automatic exp_t ex(bit rdy0, bit rdy1, bit rv0, bit rv1, bit [31:0] rd,
                              bit cv, bit [31:0] caddr, bit [31:0] cwd, bit bsy);
    exp_t e;
    e.rdy0 = rdy0; e.rdy1 = rdy1; e.rv0 = rv0; e.rv1 = rv1; e.rd = rd;
    e.cv = cv; e.caddr = caddr; e.cwd = cwd; e.busy = bsy;
    return e;
  endfunction

  // One clock: drive at negedge, compare against the model (and the vector if given), advance at posedge.
  task automatic step(input stim_t s, input bit has_e, input exp_t e);
    bit accept, elig0, win1, g0, g1, resp, x_rv0, x_rv1;
    @(negedge clk);
    rstn = s.rstn; flush = s.flush;
    rq0_valid = s.v0; rq0_op = s.op0; rq0_addr = s.a0; rq0_wtype = s.wt0; rq0_wdata = s.wd0;
    rq1_valid = s.v1; rq1_op = s.op1; rq1_addr = s.a1; rq1_wtype = s.wt1; rq1_wdata = s.wd1;
    c_data_valid = s.cdv; c_rdata = s.crd;
    #1;
    accept = !m_issue && (!m_flight || s.cdv);
    elig0  = s.v0 && !s.flush;
    win1   = s.v1 && ((m_losses >= STARVE) || !elig0);
    g1     = accept && win1;
    g0     = accept && elig0 && !win1;
    resp   = m_flight && s.cdv;
    x_rv0  = resp && !m_owner && !m_drop && !s.flush;
    x_rv1  = resp && m_owner;
    s_rdy0 = rq0_ready; s_rdy1 = rq1_ready; s_rv0 = rq0_resp_valid; s_rv1 = rq1_resp_valid;
    s_busy = busy; s_cv = c_valid; s_rd1 = rq1_rdata; s_caddr = c_addr;
    chk("rq0_ready", 32'(rq0_ready), 32'(g0));
    chk("rq1_ready", 32'(rq1_ready), 32'(g1));
    chk("rq0_resp_valid", 32'(rq0_resp_valid), 32'(x_rv0));
    chk("rq1_resp_valid", 32'(rq1_resp_valid), 32'(x_rv1));
    chk("c_valid", 32'(c_valid), 32'(m_issue));
    chk("busy", 32'(busy), 32'(m_issue || m_flight));
    chk("c_op", 32'(c_op), 32'(m_op));
    chk("c_addr", c_addr, m_addr);
    chk("c_write_type", 32'(c_write_type), 32'(m_wtype));
    chk("c_wdata", c_wdata, m_wdata);
    if (x_rv0) begin
      chk("rq0_rdata", rq0_rdata, s.crd);
      chk("rq1_rdata non-owner", rq1_rdata, 32'h0);
    end
    if (x_rv1) begin
      chk("rq1_rdata", rq1_rdata, s.crd);
      chk("rq0_rdata non-owner", rq0_rdata, 32'h0);
    end
    if (has_e) begin
      chk("vec rq0_ready", 32'(rq0_ready), 32'(e.rdy0));
      chk("vec rq1_ready", 32'(rq1_ready), 32'(e.rdy1));
      chk("vec rq0_resp_valid", 32'(rq0_resp_valid), 32'(e.rv0));
      chk("vec rq1_resp_valid", 32'(rq1_resp_valid), 32'(e.rv1));
      if (e.rv0) chk("vec rq0_rdata", rq0_rdata, e.rd);
      if (e.rv1) chk("vec rq1_rdata", rq1_rdata, e.rd);
      chk("vec c_valid", 32'(c_valid), 32'(e.cv));
      chk("vec c_addr", c_addr, e.caddr);
      chk("vec c_wdata", c_wdata, e.cwd);
      chk("vec busy", 32'(busy), 32'(e.busy));
    end
    @(posedge clk);
    if (!s.rstn) begin
      m_issue = 0; m_flight = 0; m_owner = 0; m_drop = 0; m_losses = 0;
      m_op = 0; m_addr = '0; m_wtype = '0; m_wdata = '0;
    end else begin
      if (!s.v1 || g1) m_losses = 0;
      else if (g0 && m_losses < 7) m_losses++;
      if (g0 || g1) begin
        m_owner = g1; m_drop = 0; m_issue = 1; m_flight = 0;
        m_op    = g1 ? s.op1 : s.op0;
        m_addr  = g1 ? s.a1  : s.a0;
        m_wtype = g1 ? s.wt1 : s.wt0;
        m_wdata = g1 ? s.wd1 : s.wd0;
      end else if (m_issue) begin
        m_issue = 0; m_flight = 1;
        if (s.flush && !m_owner) m_drop = 1;
      end else if (m_flight) begin
        if (s.cdv) m_flight = 0;
        else if (s.flush && !m_owner) m_drop = 1;
      end
    end
  endtask

  initial begin
    vec_t  tbl[16];
    exp_t  e0;
    stim_t idle;
    stim_t rs;
    bit    gq[$];
    bit    exp_g[6];

    e0 = ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset, single read (3-cycle cache), back-to-back writes, flush-blocked rq0.
    tbl[0]  = '{s: mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),                 e: ex(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{s: mk(1, 0, 1, 0, 32'h1000, 0, 0, 0, 0, 0),          e: ex(1, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{s: idle,                                             e: ex(0, 0, 0, 0, 0, 1, 32'h1000, 0, 1)};
    tbl[3]  = '{s: idle,                                             e: ex(0, 0, 0, 0, 0, 0, 32'h1000, 0, 1)};
    tbl[4]  = '{s: idle,                                             e: ex(0, 0, 0, 0, 0, 0, 32'h1000, 0, 1)};
    tbl[5]  = '{s: mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF),      e: ex(0, 0, 1, 0, 32'hDEADBEEF, 0, 32'h1000, 0, 1)};
    tbl[6]  = '{s: idle,                                             e: ex(0, 0, 0, 0, 0, 0, 32'h1000, 0, 0)};
    tbl[7]  = '{s: mk(1, 0, 1, 1, 32'h2000, 32'h11, 0, 0, 0, 0),     e: ex(1, 0, 0, 0, 0, 0, 32'h1000, 0, 0)};
    tbl[8]  = '{s: mk(1, 0, 1, 1, 32'h2004, 32'h22, 0, 0, 0, 0),     e: ex(0, 0, 0, 0, 0, 1, 32'h2000, 32'h11, 1)};
    tbl[9]  = '{s: mk(1, 0, 1, 1, 32'h2004, 32'h22, 0, 0, 1, 0),     e: ex(1, 0, 1, 0, 0, 0, 32'h2000, 32'h11, 1)};
    tbl[10] = '{s: idle,                                             e: ex(0, 0, 0, 0, 0, 1, 32'h2004, 32'h22, 1)};
    tbl[11] = '{s: mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0),                 e: ex(0, 0, 1, 0, 0, 0, 32'h2004, 32'h22, 1)};
    tbl[12] = '{s: mk(1, 1, 1, 0, 32'h3000, 0, 1, 32'h4000, 0, 0),   e: ex(0, 1, 0, 0, 0, 0, 32'h2004, 32'h22, 0)};
    tbl[13] = '{s: idle,                                             e: ex(0, 0, 0, 0, 0, 1, 32'h4000, 0, 1)};
    tbl[14] = '{s: mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE0001),      e: ex(0, 0, 0, 1, 32'hCAFE0001, 0, 32'h4000, 0, 1)};
    tbl[15] = '{s: idle,                                             e: ex(0, 0, 0, 0, 0, 0, 32'h4000, 0, 0)};

    for (int i = 0; i < 16; i++) step(tbl[i].s, 1'b1, tbl[i].e);

    // Contention: both requesters held, cache answers one cycle after c_valid.
    for (int i = 0; i < 14; i++) begin
      step(mk(1, 0, 1, 0, 32'h5000, 0, 1, 32'h6000, 1, 32'(i)), 1'b0, e0);
      if (s_rdy0) gq.push_back(1'b0);
      if (s_rdy1) gq.push_back(1'b1);
    end
    exp_g = '{0, 0, 0, 0, 1, 0};
    chk("contention grant count", 32'(gq.size() >= 6), 32'h1);
    for (int i = 0; i < 6; i++) begin
      if (i < gq.size()) chk($sformatf("contention grant %0d", i), 32'(gq[i]), 32'(exp_g[i]));
    end
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, e0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, e0);
    step(idle, 1'b0, e0);

    // Flush pulse while rq0 read waits: response dropped, rq1 then served normally.
    step(mk(1, 0, 1, 0, 32'h7000, 0, 0, 0, 0, 0), 1'b0, e0);
    step(idle, 1'b0, e0);
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, e0);
    step(idle, 1'b0, e0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678), 1'b0, e0);
    chk("flushed rq0 resp", 32'(s_rv0), 32'h0);
    step(mk(1, 0, 0, 0, 0, 0, 1, 32'h8000, 0, 0), 1'b0, e0);
    chk("rq1 after flush ready", 32'(s_rdy1), 32'h1);
    step(idle, 1'b0, e0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5), 1'b0, e0);
    chk("rq1 after flush resp", 32'(s_rv1), 32'h1);
    chk("rq1 after flush rdata", s_rd1, 32'hA5A5A5A5);

    // Reset while waiting; the late cache answer must be ignored.
    step(mk(1, 0, 1, 0, 32'h9000, 0, 0, 0, 0, 0), 1'b0, e0);
    step(idle, 1'b0, e0);
    step(idle, 1'b0, e0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, e0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0), 1'b0, e0);
    chk("post-reset resp", 32'(s_rv0), 32'h0);
    chk("post-reset busy", 32'(s_busy), 32'h0);
    chk("post-reset c_valid", 32'(s_cv), 32'h0);
    chk("post-reset c_addr", s_caddr, 32'h0);

    // Random traffic, including illegal c_data_valid and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rs.rstn  = ($urandom_range(0, 99) != 0);
      rs.flush = ($urandom_range(0, 9) == 0);
      rs.v0    = 1'($urandom);
      rs.op0   = 1'($urandom);
      rs.a0    = 32'($urandom);
      rs.wt0   = 4'($urandom);
      rs.wd0   = 32'($urandom);
      rs.v1    = ($urandom_range(0, 3) != 0);
      rs.op1   = 1'($urandom);
      rs.a1    = 32'($urandom);
      rs.wt1   = 4'($urandom);
      rs.wd1   = 32'($urandom);
      rs.cdv   = ($urandom_range(0, 2) == 0);
      rs.crd   = 32'($urandom);
      step(rs, 1'b0, e0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
